// File: rtl/id_ex_stage_pkg.sv
// Shared CPU types: datapath width, control bundle and op encodings.
// Imported by the ID/EX pipeline register and its forwarding muxes.
package id_ex_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LB   = 3'd1,
    MEM_LH   = 3'd2,
    MEM_LW   = 3'd3,
    MEM_SB   = 3'd4,
    MEM_SH   = 3'd5,
    MEM_SW   = 3'd6
  } mem_op_e;

  typedef struct packed {
    logic    reg_we;
    logic    is_load;
    alu_op_e alu_op;
    mem_op_e mem_op;
    logic    is_branch;
    logic    is_jump;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand bypass select: EX result, then MEM writeback, then RF data.
// x0 and unused operands always take the register-file value.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = id_ex_stage_pkg::XLEN
) (
  input  logic [4:0]      rs,
  input  logic            use_rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_hit_en,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_hit_en,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic [XLEN-1:0] val
);

  logic active;
  logic ex_hit;
  logic mem_hit;

  assign active  = use_rs && (rs != 5'd0);
  assign ex_hit  = active && ex_hit_en && (ex_rd == rs);
  assign mem_hit = active && mem_hit_en && (mem_rd == rs);

  always_comb begin
    val = rf_data;
    if (ex_hit) begin
      val = ex_data;
    end else if (mem_hit) begin
      val = mem_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubbles.
// Edge priority: reset, flush, downstream stall, load-use, capture.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = id_ex_stage_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  ctrl_t           id_ctrl,
  input  logic [XLEN-1:0] ex_result,
  input  logic            mem_valid,
  input  logic            mem_we,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            flush,
  input  logic            stall_in,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output ctrl_t           ex_ctrl,
  output logic            id_stall,
  output logic [31:0]     bubble_cnt
);

  logic            ex_fwd_en;
  logic            mem_fwd_en;
  logic            rs1_match;
  logic            rs2_match;
  logic            load_use;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // A load's EX result is an address, not data, so it never bypasses.
  assign ex_fwd_en  = ex_valid && ex_ctrl.reg_we
                   && !ex_ctrl.is_load;
  assign mem_fwd_en = mem_valid && mem_we;

  assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use  = id_valid && ex_valid
                  && ex_ctrl.is_load
                  && (ex_rd != 5'd0)
                  && (rs1_match || rs2_match);

  assign id_stall = !flush && (stall_in || load_use);

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs         (id_rs1),
    .use_rs     (id_use_rs1),
    .rf_data    (id_rs1_data),
    .ex_hit_en  (ex_fwd_en),
    .ex_rd      (ex_rd),
    .ex_data    (ex_result),
    .mem_hit_en (mem_fwd_en),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .val        (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs         (id_rs2),
    .use_rs     (id_use_rs2),
    .rf_data    (id_rs2_data),
    .ex_hit_en  (ex_fwd_en),
    .ex_rd      (ex_rd),
    .ex_data    (ex_result),
    .mem_hit_en (mem_fwd_en),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .val        (rs2_fwd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (stall_in) begin
      ex_valid <= ex_valid;
    end else if (load_use) begin
      ex_valid <= 1'b0;
      if (bubble_cnt != 32'hFFFF_FFFF) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end else begin
      ex_valid   <= id_valid;
      ex_pc      <= id_pc;
      ex_rs1_val <= rs1_fwd;
      ex_rs2_val <= rs2_fwd;
      ex_imm     <= id_imm;
      ex_rd      <= id_rd;
      ex_ctrl    <= id_ctrl;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         id_valid;
  logic [W-1:0] id_pc;
  logic [4:0]   id_rs1;
  logic [4:0]   id_rs2;
  logic [4:0]   id_rd;
  logic         id_use_rs1;
  logic         id_use_rs2;
  logic [W-1:0] id_rs1_data;
  logic [W-1:0] id_rs2_data;
  logic [W-1:0] id_imm;
  ctrl_t        id_ctrl;
  logic [W-1:0] ex_result;
  logic         mem_valid;
  logic         mem_we;
  logic [4:0]   mem_rd;
  logic [W-1:0] mem_data;
  logic         flush;
  logic         stall_in;
  logic         ex_valid;
  logic [W-1:0] ex_pc;
  logic [W-1:0] ex_rs1_val;
  logic [W-1:0] ex_rs2_val;
  logic [W-1:0] ex_imm;
  logic [4:0]   ex_rd;
  ctrl_t        ex_ctrl;
  logic         id_stall;
  logic [31:0]  bubble_cnt;

  int checks;
  int errors;

  // Reference model state: the instruction the EX stage should hold.
  logic         m_valid;
  logic [W-1:0] m_pc;
  logic [W-1:0] m_rs1;
  logic [W-1:0] m_rs2;
  logic [W-1:0] m_imm;
  logic [4:0]   m_rd;
  ctrl_t        m_ctrl;
  logic [31:0]  m_bub;

  id_ex_stage #(.XLEN(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .id_imm      (id_imm),
    .id_ctrl     (id_ctrl),
    .ex_result   (ex_result),
    .mem_valid   (mem_valid),
    .mem_we      (mem_we),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .flush       (flush),
    .stall_in    (stall_in),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_rs1_val  (ex_rs1_val),
    .ex_rs2_val  (ex_rs2_val),
    .ex_imm      (ex_imm),
    .ex_rd       (ex_rd),
    .ex_ctrl     (ex_ctrl),
    .id_stall    (id_stall),
    .bubble_cnt  (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_operand(
    input logic [4:0] rs, input logic use_it,
    input logic [W-1:0] rf);
    if (!use_it || rs == 5'd0) return rf;
    if (m_valid && m_ctrl.reg_we && !m_ctrl.is_load
        && m_rd == rs) return ex_result;
    if (mem_valid && mem_we && mem_rd == rs) return mem_data;
    return rf;
  endfunction

  function automatic logic ref_load_use();
    logic hit;
    hit = (id_use_rs1 && id_rs1 == m_rd)
       || (id_use_rs2 && id_rs2 == m_rd);
    return id_valid && m_valid && m_ctrl.is_load
        && m_rd != 5'd0 && hit;
  endfunction

  function automatic logic ref_stall();
    return !flush && (stall_in || ref_load_use());
  endfunction

  task automatic model_edge();
    logic [W-1:0] f1;
    logic [W-1:0] f2;
    logic lu;
    f1 = ref_operand(id_rs1, id_use_rs1, id_rs1_data);
    f2 = ref_operand(id_rs2, id_use_rs2, id_rs2_data);
    lu = ref_load_use();
    if (!rst_n) begin
      m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0;
      m_imm = 0; m_rd = 0; m_ctrl = '0; m_bub = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (stall_in) begin
      m_valid = m_valid;
    end else if (lu) begin
      m_valid = 0;
      if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
    end else begin
      m_valid = id_valid; m_pc = id_pc;
      m_rs1 = f1; m_rs2 = f2; m_imm = id_imm;
      m_rd = id_rd; m_ctrl = id_ctrl;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0;
    id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_ctrl = '0; ex_result = 0; mem_valid = 0;
    mem_we = 0; mem_rd = 0; mem_data = 0;
    flush = 0; stall_in = 0;
  endtask

  function automatic ctrl_t mk_ctrl(input logic we,
                                    input logic ld);
    ctrl_t c;
    c = '0;
    c.reg_we = we;
    c.is_load = ld;
    c.alu_op = ALU_ADD;
    c.mem_op = ld ? MEM_LW : MEM_NONE;
    return c;
  endfunction

  task automatic set_id(input logic [W-1:0] pc,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic u1, input logic u2,
    input logic [W-1:0] d1, input logic [W-1:0] d2,
    input ctrl_t c);
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2;
    id_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rs1_data = d1; id_rs2_data = d2;
    id_imm = pc ^ 32'h5A5A; id_ctrl = c;
  endtask

  task automatic test_reset();
    clear_inputs();
    set_id(32'hDEAD, 5'd1, 5'd2, 5'd3, 1, 1,
           32'h11, 32'h22, mk_ctrl(1, 0));
    flush = 1; stall_in = 1; rst_n = 0;
    cycle();
    cycle();
    checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_valid_cnt: got v=%b cnt=%0d exp v=0 cnt=0",
               ex_valid, bubble_cnt);
    end
    checks++;
    if ({ex_pc, ex_rs1_val, ex_rs2_val, ex_imm} !== '0
        || ex_rd !== 5'd0 || ex_ctrl !== '0) begin
      errors++;
      $display("FAIL reset_fields: got pc=%h r1=%h r2=%h rd=%0d exp all 0",
               ex_pc, ex_rs1_val, ex_rs2_val, ex_rd);
    end
    rst_n = 1;
    clear_inputs();
    cycle();
  endtask

  task automatic test_ex_fwd();
    clear_inputs();
    set_id(32'h40, 5'd1, 5'd2, 5'd5, 1, 1, 0, 0, mk_ctrl(1, 0));
    cycle();
    set_id(32'h44, 5'd5, 5'd6, 5'd8, 1, 1, 0, 32'h3, mk_ctrl(1, 0));
    ex_result = 32'h10;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL ex_fwd_stall: got %b exp 0", id_stall);
    end
    cycle();
    checks++;
    if (ex_rs1_val !== 32'h10 || ex_rs2_val !== 32'h3
        || ex_valid !== 1'b1 || ex_pc !== 32'h44) begin
      errors++;
      $display("FAIL ex_fwd: got r1=%h r2=%h v=%b pc=%h exp 10 3 1 44",
               ex_rs1_val, ex_rs2_val, ex_valid, ex_pc);
    end
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    set_id(32'h80, 5'd1, 5'd2, 5'd7, 1, 1, 0, 0, mk_ctrl(1, 0));
    cycle();
    set_id(32'h84, 5'd7, 5'd0, 5'd9, 1, 0, 32'h1, 0, mk_ctrl(1, 0));
    ex_result = 32'hAA;
    mem_valid = 1; mem_we = 1; mem_rd = 5'd7; mem_data = 32'hBB;
    cycle();
    checks++;
    if (ex_rs1_val !== 32'hAA) begin
      errors++;
      $display("FAIL fwd_ex_wins: got %h exp aa", ex_rs1_val);
    end
    set_id(32'h88, 5'd1, 5'd2, 5'd7, 1, 1, 0, 0, mk_ctrl(0, 0));
    mem_valid = 0;
    cycle();
    set_id(32'h8C, 5'd7, 5'd7, 5'd9, 1, 1, 32'h1, 32'h2,
           mk_ctrl(1, 0));
    ex_result = 32'hAA;
    mem_valid = 1; mem_we = 1; mem_rd = 5'd7; mem_data = 32'hBB;
    cycle();
    checks++;
    if (ex_rs1_val !== 32'hBB || ex_rs2_val !== 32'hBB) begin
      errors++;
      $display("FAIL fwd_mem: got r1=%h r2=%h exp bb bb",
               ex_rs1_val, ex_rs2_val);
    end
    set_id(32'h90, 5'd7, 5'd7, 5'd9, 0, 1, 32'h31, 32'h32,
           mk_ctrl(1, 0));
    cycle();
    checks++;
    if (ex_rs1_val !== 32'h31 || ex_rs2_val !== 32'hBB) begin
      errors++;
      $display("FAIL fwd_unused: got r1=%h r2=%h exp 31 bb",
               ex_rs1_val, ex_rs2_val);
    end
  endtask

  task automatic test_x0();
    clear_inputs();
    set_id(32'hC0, 5'd1, 5'd2, 5'd0, 1, 1, 0, 0, mk_ctrl(1, 0));
    cycle();
    set_id(32'hC4, 5'd0, 5'd0, 5'd4, 1, 1, 0, 0, mk_ctrl(1, 0));
    ex_result = 32'hFFFF;
    mem_valid = 1; mem_we = 1; mem_rd = 5'd0; mem_data = 32'h77;
    cycle();
    checks++;
    if (ex_rs1_val !== 32'h0 || ex_rs2_val !== 32'h0) begin
      errors++;
      $display("FAIL x0_fwd: got r1=%h r2=%h exp 0 0",
               ex_rs1_val, ex_rs2_val);
    end
    clear_inputs();
    set_id(32'hC8, 5'd1, 5'd2, 5'd0, 1, 0, 0, 0, mk_ctrl(1, 1));
    cycle();
    set_id(32'hCC, 5'd0, 5'd0, 5'd4, 1, 1, 0, 0, mk_ctrl(1, 0));
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL x0_load_stall: got %b exp 0", id_stall);
    end
    cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_id(32'h100, 5'd1, 5'd0, 5'd3, 1, 0, 0, 0, mk_ctrl(1, 1));
    cycle();
    set_id(32'h104, 5'd0, 5'd3, 5'd6, 0, 1, 0, 0, mk_ctrl(1, 0));
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got %b exp 1", id_stall);
    end
    cycle();
    checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 32'd1) begin
      errors++;
      $display("FAIL lu_bubble: got v=%b cnt=%0d exp v=0 cnt=1",
               ex_valid, bubble_cnt);
    end
    mem_valid = 1; mem_we = 1; mem_rd = 5'd3; mem_data = 32'h1234;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_release: got %b exp 0", id_stall);
    end
    cycle();
    checks++;
    if (ex_rs2_val !== 32'h1234 || ex_valid !== 1'b1
        || ex_pc !== 32'h104 || bubble_cnt !== 32'd1) begin
      errors++;
      $display("FAIL lu_data: got r2=%h v=%b pc=%h cnt=%0d exp 1234 1 104 1",
               ex_rs2_val, ex_valid, ex_pc, bubble_cnt);
    end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    set_id(32'h200, 5'd1, 5'd2, 5'd9, 1, 1, 32'hA1, 32'hA2,
           mk_ctrl(1, 0));
    cycle();
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(32'h300 + i, 5'd9, 5'd9, 5'd10, 1, 1,
             $urandom, $urandom, mk_ctrl(1, 0));
      ex_result = $urandom;
      #1;
      checks++;
      if (id_stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_id_stall: got %b exp 1", id_stall);
      end
      cycle();
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h200
          || ex_rs1_val !== 32'hA1 || ex_rs2_val !== 32'hA2
          || ex_rd !== 5'd9) begin
        errors++;
        $display("FAIL stall_hold: got v=%b pc=%h r1=%h r2=%h rd=%0d exp 1 200 a1 a2 9",
                 ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_rd);
      end
    end
    flush = 1;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b exp 0", id_stall);
    end
    cycle();
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got %b exp 0", ex_valid);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    set_id(32'h400, 5'd1, 5'd0, 5'd4, 1, 0, 0, 0, mk_ctrl(1, 1));
    cycle();
    set_id(32'h404, 5'd4, 5'd0, 5'd6, 1, 0, 0, 0, mk_ctrl(1, 0));
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got %b exp 1", id_stall);
    end
    rst_n = 0;
    cycle();
    checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 32'd0
        || ex_pc !== '0 || ex_rd !== 5'd0
        || ex_ctrl !== '0 || ex_rs1_val !== '0) begin
      errors++;
      $display("FAIL rst_mid: got v=%b cnt=%0d pc=%h rd=%0d exp all 0",
               ex_valid, bubble_cnt, ex_pc, ex_rd);
    end
    rst_n = 1;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_post: got %b exp 0", id_stall);
    end
    stall_in = 1;
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_follow: got %b exp 1", id_stall);
    end
    clear_inputs();
    cycle();
  endtask

  task automatic test_random();
    ctrl_t c;
    for (int i = 0; i < 400; i++) begin
      c = '0;
      c.reg_we = $urandom_range(0, 3) != 0;
      c.is_load = $urandom_range(0, 2) == 0;
      c.alu_op = alu_op_e'($urandom_range(0, 9));
      c.mem_op = mem_op_e'($urandom_range(0, 6));
      c.is_branch = $urandom_range(0, 1);
      c.is_jump = $urandom_range(0, 1);
      set_id($urandom, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom, $urandom, c);
      id_valid = $urandom_range(0, 4) != 0;
      ex_result = $urandom;
      mem_valid = $urandom_range(0, 1);
      mem_we = $urandom_range(0, 3) != 0;
      mem_rd = 5'($urandom_range(0, 7));
      mem_data = $urandom;
      flush = $urandom_range(0, 9) == 0;
      stall_in = $urandom_range(0, 5) == 0;
      rst_n = $urandom_range(0, 59) != 0;
      #1;
      checks++;
      if (id_stall !== ref_stall()) begin
        errors++;
        $display("FAIL rnd_stall[%0d]: got %b exp %b",
                 i, id_stall, ref_stall());
      end
      cycle();
      checks++;
      if (ex_valid !== m_valid || bubble_cnt !== m_bub) begin
        errors++;
        $display("FAIL rnd_state[%0d]: got v=%b cnt=%0d exp v=%b cnt=%0d",
                 i, ex_valid, bubble_cnt, m_valid, m_bub);
      end
      if (m_valid) begin
        checks++;
        if (ex_pc !== m_pc || ex_rs1_val !== m_rs1
            || ex_rs2_val !== m_rs2 || ex_imm !== m_imm
            || ex_rd !== m_rd || ex_ctrl !== m_ctrl) begin
          errors++;
          $display("FAIL rnd_fields[%0d]: got pc=%h r1=%h r2=%h rd=%0d exp pc=%h r1=%h r2=%h rd=%0d",
                   i, ex_pc, ex_rs1_val, ex_rs2_val, ex_rd,
                   m_pc, m_rs1, m_rs2, m_rd);
        end
      end
    end
    rst_n = 1;
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 0;
    m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0;
    m_imm = 0; m_rd = 0; m_ctrl = '0; m_bub = 0;
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_ex_fwd();
    test_fwd_priority();
    test_x0();
    test_load_use();
    test_stall_flush();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC, operands and immediate.
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 id_valid  input  1  decode stage holds a valid instruction.
REQ-005 id_pc  input  XLEN  PC of decode instruction.
REQ-006 id_rs1, id_rs2, id_rd  input  5 each  source and destination register indices.
REQ-007 id_use_rs1, id_use_rs2  input  1 each  instruction reads rs1 / rs2.
REQ-008 id_rs1_data, id_rs2_data  input  XLEN each  register-file read data, already WB-bypassed.
REQ-009 id_imm  input  XLEN  decoded immediate.
REQ-010 id_ctrl  input  ctrl_t  control bundle (reg_we, is_load, alu_op, mem_op, branch fields).
REQ-011 ex_result  input  XLEN  ALU result of the instruction currently held in this stage's outputs.
REQ-012 mem_valid, mem_we  input  1 each; mem_rd  input  5; mem_data  input  XLEN  MEM-stage writeback candidate.
REQ-013 flush  input  1  branch redirect; kill decode and EX instructions.
REQ-014 stall_in  input  1  downstream hold (cache miss).
REQ-015 ex_valid  output  1; ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  output  XLEN each; ex_rd  output  5; ex_ctrl  output  ctrl_t  registered EX-stage instruction.
REQ-016 id_stall  output  1  combinational; fetch/decode must hold when high.
REQ-017 bubble_cnt  output  32  count of load-use bubbles inserted.

Function
REQ-018 Forwarding for each operand SHALL select: EX source (ex_valid, ex_ctrl.reg_we, !ex_ctrl.is_load, ex_rd==rsX, rsX!=0) first, else MEM source (mem_valid, mem_we, mem_rd==rsX, rsX!=0), else id_rsX_data.
REQ-019 Index 0 SHALL never be forwarded; operand of x0 equals id_rsX_data.
REQ-020 Forwarding SHALL apply only when id_use_rsX=1.
REQ-021 Load-use hazard SHALL be asserted when id_valid, ex_valid, ex_ctrl.is_load, ex_rd!=0 and ex_rd matches a used source.
REQ-022 id_stall SHALL equal stall_in OR load-use hazard, and SHALL be 0 when flush=1.
REQ-023 Per-edge priority: reset > flush > stall_in > load-use > capture.
REQ-024 flush: next cycle ex_valid=0; other fields don't-care.
REQ-025 stall_in (no flush): all output registers hold.
REQ-026 Load-use (no flush, no stall_in): ex_valid<=0 (bubble) next cycle; decode instruction re-presented and captured one cycle later, taking load data via MEM forwarding.
REQ-027 Capture: all outputs load from decode inputs with forwarded operands; ex_valid<=id_valid; latency one cycle.
REQ-028 bubble_cnt SHALL increment by 1 per inserted load-use bubble and saturate at 0xFFFF_FFFF.

Reset
REQ-029 With rst_n=0 at a clock edge: ex_valid=0, bubble_cnt=0, ex_pc/ex_rs1_val/ex_rs2_val/ex_imm=0, ex_rd=0, ex_ctrl=all-zero (NOP); overrides flush and stall_in.
REQ-030 Reset asserted mid-stall SHALL drop the held instruction; id_stall follows inputs combinationally after reset.

Structure
REQ-031 ctrl_t, alu_op/mem_op enums and XLEN SHALL reside in the shared CPU types package.
REQ-032 One sub-module fwd_mux (per-operand priority select) SHALL be instantiated twice.

Verification
REQ-033 add x5 in EX (ex_result=0x10), decode add uses x5 with id_rs1_data=0x0 -> ex_rs1_val=0x10 next cycle.
REQ-034 EX and MEM both write x7 (0xAA, 0xBB) -> operand = 0xAA (EX wins); EX not writing -> 0xBB.
REQ-035 lw x3 in EX, decode uses x3 -> id_stall=1 one cycle, ex_valid=0, bubble_cnt 0->1; next cycle mem_data=0x1234 -> ex_rs2_val=0x1234.
REQ-036 Producer rd=0 with result 0xFFFF -> consumer of x0 gets id_rs1_data (0), no stall for load to x0.
REQ-037 stall_in=1 for 3 cycles -> outputs constant; flush during stall_in -> ex_valid=0 next cycle.
REQ-038 rst_n=0 during load-use stall -> all outputs zero, bubble_cnt=0 after edge.
